// File: rtl/memtile_pkg.sv
// Shared definitions for the memory tile unit's external-bus sequencer.
// Holds the scheduler state encoding, tile geometry, requester side
// encoding and the access-mode codes also used by the tile unit.
package memtile_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int TILE_WORDS = 16;

  // Requester side encoding, also the encoding of the arbiter's history bit
  localparam logic SIDE_I = 1'b1;
  localparam logic SIDE_D = 1'b0;

  // Access modes shared with the tile unit
  localparam logic [1:0] MD_NONE  = 2'd0;
  localparam logic [1:0] MD_READ  = 2'd1;
  localparam logic [1:0] MD_WRITE = 2'd2;
  localparam logic [1:0] MD_RMW   = 2'd3;

endpackage

// File: rtl/memtile_rr_arb2.sv
// Two-requester round-robin arbiter (I side vs D side).
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   req_i/req_d - request from I side / D side
//   grant_en    - a grant is being taken this cycle; updates the history
//   gnt_i/gnt_d - combinational one-hot grant (both 0 when idle)
// With both requesting, the side that did not win last time is chosen.
// The history bit resets to SIDE_I, so the D side wins the first tie.
module memtile_rr_arb2
  import memtile_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req_i,
  input  logic req_d,
  input  logic grant_en,
  output logic gnt_i,
  output logic gnt_d
);

  logic last_q;

  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    if (req_i && req_d) begin
      if (last_q == SIDE_I) gnt_d = 1'b1;
      else                  gnt_i = 1'b1;
    end else begin
      gnt_i = req_i;
      gnt_d = req_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= SIDE_I;
    end else if (grant_en && (req_i || req_d)) begin
      last_q <= gnt_i ? SIDE_I : SIDE_D;
    end
  end

endmodule

// File: rtl/memtile_ext_sched.sv
// External memory bus scheduler for the memory tile unit.
// Arbitrates I/D tile misses, writes back a dirty D victim tile, then
// fills the new tile word by word with extNotReady wait states.
// Ports:
//   clk, reset                  - clock, synchronous active-high reset
//   iReq/iReqAddr               - I miss request and fill address
//   dReq/dReqWb/dReqAddr/dWbAddr- D miss request, dirty flag, fill and victim addresses
//   wbData                      - victim word at xferIdx (async tile RAM read)
//   fillData/fillWe/fillIsI     - tile RAM write port and target select
//   xferIdx                     - current word index within the tile
//   iDone/dDone                 - one-cycle completion pulses
//   extAddr/extDataOut/extDataIn/extOE/extWR/extHold/extNotReady - external bus
module memtile_ext_sched
  import memtile_pkg::*;
#(
  parameter int ADDR_W = 48,
  parameter int WIDX_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iReq,
  input  logic [ADDR_W-1:0] iReqAddr,
  input  logic              dReq,
  input  logic              dReqWb,
  input  logic [ADDR_W-1:0] dReqAddr,
  input  logic [ADDR_W-1:0] dWbAddr,
  input  logic [31:0]       wbData,
  output logic [31:0]       fillData,
  output logic              fillWe,
  output logic              fillIsI,
  output logic [WIDX_W-1:0] xferIdx,
  output logic              iDone,
  output logic              dDone,
  output logic [ADDR_W-1:0] extAddr,
  output logic [31:0]       extDataOut,
  input  logic [31:0]       extDataIn,
  output logic              extOE,
  output logic              extWR,
  output logic              extHold,
  input  logic              extNotReady
);

  localparam int OFF_W  = WIDX_W + 2;
  localparam int BASE_W = ADDR_W - OFF_W;

  state_t            state_q, state_d;
  logic [WIDX_W-1:0] idx_q;
  logic              side_i_q;
  logic [BASE_W-1:0] fill_base_q;
  logic [BASE_W-1:0] wb_base_q;
  logic              gnt_i, gnt_d, grant;
  logic              accept, last_word;

  // Byte offset within a tile is implied by xferIdx, so the low address bits are dropped
  logic unused_addr_bits;
  assign unused_addr_bits = ^{iReqAddr[OFF_W-1:0], dReqAddr[OFF_W-1:0], dWbAddr[OFF_W-1:0]};

  memtile_rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req_i   (iReq),
    .req_d   (dReq),
    .grant_en(state_q == IDLE),
    .gnt_i   (gnt_i),
    .gnt_d   (gnt_d)
  );

  assign grant     = (state_q == IDLE) && (gnt_i || gnt_d);
  assign accept    = !extNotReady;
  assign last_word = (idx_q == WIDX_W'(TILE_WORDS - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_d && dReqWb)     state_d = WB;
        else if (gnt_i || gnt_d) state_d = FILL;
      end
      WB:   if (accept && last_word) state_d = FILL;
      FILL: if (accept && last_word) state_d = DONE;
      DONE: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      side_i_q <= 1'b0;
    end else begin
      state_q <= state_d;
      // Index wraps to 0 naturally after word 15, ready for the next phase
      if ((state_q == WB || state_q == FILL) && accept) idx_q <= idx_q + WIDX_W'(1);
      if (grant) side_i_q <= gnt_i;
    end
  end

  // Tile bases are only captured at grant, so request inputs may change freely afterwards
  always_ff @(posedge clk) begin
    if (grant && gnt_i) begin
      fill_base_q <= iReqAddr[ADDR_W-1:OFF_W];
    end else if (grant && gnt_d) begin
      fill_base_q <= dReqAddr[ADDR_W-1:OFF_W];
      wb_base_q   <= dWbAddr[ADDR_W-1:OFF_W];
    end
  end

  always_comb begin
    extOE      = 1'b0;
    extWR      = 1'b0;
    extAddr    = '0;
    extDataOut = '0;
    fillWe     = 1'b0;
    fillData   = '0;
    fillIsI    = 1'b0;
    iDone      = 1'b0;
    dDone      = 1'b0;
    unique case (state_q)
      IDLE: ;
      WB: begin
        extWR      = 1'b1;
        extAddr    = {wb_base_q, idx_q, 2'b00};
        extDataOut = wbData;
      end
      FILL: begin
        extOE    = 1'b1;
        extAddr  = {fill_base_q, idx_q, 2'b00};
        fillWe   = accept;
        fillData = extDataIn;
        fillIsI  = side_i_q;
      end
      DONE: begin
        iDone = side_i_q;
        dDone = !side_i_q;
      end
    endcase
  end

  assign extHold = (state_q != IDLE);
  assign xferIdx = idx_q;

endmodule
